spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
Native-RTL, parametrised SPI master peripheral for the CPU I/O bus, replacing the fixed 8-bit vendor SPI wrapper. It supports configurable frame width, chip-select count, all four SPI modes, MSB/LSB-first ordering and a programmable SCLK divider. The CPU drives it through the shared tristate data bus with chip-enable/direction strobes and a small register map.

Parameters:
DATA_W, 8, SPI frame width in bits (2..32, must be <= `LEN).
IONUM, 1, number of active-low chip-select lines (1..8).
DIV_W, 8, width of the SCLK divider register.

Ports:
clk_in  input  1  system clock
rst  input  1  asynchronous active-low reset
en_cs  input  1  peripheral select; a bus access occurs only when high
en_i  input  1  direction with en_cs: 1 = CPU write, 0 = CPU read
addr_i  input  `LEN  register address; only bits [1:0] decoded
data  inout  `LEN  CPU data bus; driven only when en_cs=1 and en_i=0, else 'z
MISO  input  1  serial data in
MOSI  output  1  serial data out
SCLK  output  1  serial clock
CS  output  IONUM  active-low chip selects

Behaviour:
- Register map:
  - 0 DATA. Write loads TX and starts a frame. Read returns the RX frame zero-extended and clears DONE.
  - 1 CTRL: [0] CPOL, [1] CPHA, [2] LSB_FIRST, [5:3] CS_SEL, [6] IE (used only by the optional feature).
  - 2 DIV.
  - 3 STATUS (read-only): [0] BUSY, [1] DONE, [2] OVR.
- Write timing: writes take effect on the clk_in edge where en_cs=1 and en_i=1.
- Read timing: read data is combinational from the registers, and clears occur on that edge.
- Reset values: SCLK=0, MOSI=0, CS=all 1s, CTRL=0, DIV=0, RX=0, BUSY/DONE/OVR=0, state IDLE.
- Half period: T = DIV+1 clk_in cycles, counted by a DIV_W+1-bit counter.
- FSM IDLE:
  - SCLK=CPOL, CS all 1s.
  - A DATA write loads the shift register, sets BUSY, and moves to SETUP.
  - A CTRL write while BUSY is ignored.
- FSM SETUP:
  - CS[CS_SEL] goes low on entry.
  - If CPHA=0, the first bit is presented on MOSI.
  - Stays T cycles, then moves to SHIFT.
- FSM SHIFT:
  - 2*DATA_W SCLK edges, each after T cycles.
  - CPHA=0: sample MISO on leading edges, shift MOSI on trailing edges.
  - CPHA=1: shift on leading edges, sample on trailing edges.
  - After the last edge, moves to HOLD.
- FSM HOLD:
  - Stays T cycles with SCLK=CPOL.
  - Then CS is released, RX is updated, DONE=1, BUSY=0, and the FSM returns to IDLE.
- Bit order: LSB_FIRST=0 shifts the MSB first; 1 shifts bit 0 first. RX assembles in the same order.
- Out-of-range select: CS_SEL >= IONUM asserts no CS line, but the frame still runs.
- Write to DATA while BUSY: ignored, OVR set. OVR is cleared by a STATUS read.
- Same-cycle frame end and DATA read: DONE is set (the end takes priority) and the read returns the old RX.
- DATA write on the completion cycle (state HOLD end): treated as BUSY, so it is ignored and OVR is set.
- Reset mid-frame: all outputs return immediately (asynchronously) to reset values, with no partial RX update.

Optional Feature:
- Macro: SPI_IRQ_EN.
- When defined: adds output irq (1 bit, reset 0), registered, equal to IE & DONE. It rises one clk_in after DONE sets and falls one cycle after the DONE-clearing DATA read.
- When undefined: no irq port, and CTRL[6] is read/write storage with no effect.

Test Plan:
- Reset check: hold rst=0, then release -> SCLK=0, CS=1, MOSI=0, STATUS reads 0.
- Mode 0, MSB first:
  - Stimulus: CTRL=0, DIV=1, write DATA=0xA5, MISO loopback to MOSI.
  - Response: CS low, 8 SCLK periods of 4 clk_in each, MOSI bits 1,0,1,0,0,1,0,1, DONE=1, DATA read=0xA5, DONE then 0.
- Mode 3, LSB first:
  - Stimulus: CTRL=0x07, DIV=0, MISO tied 1, write 0x3C.
  - Response: SCLK idles high, MOSI bits 0,0,1,1,1,1,0,0, RX=0xFF.
- Overrun and out-of-range select:
  - Write DATA twice within a frame -> OVR=1 and the second value is never transmitted. STATUS read -> OVR cleared.
  - CS_SEL=5 with IONUM=1 -> CS stays 1 and the frame still completes.
- Mid-frame reset: assert rst after 3 SCLK edges -> SCLK/CS/MOSI return to reset values immediately, and RX stays 0.
- IRQ (SPI_IRQ_EN defined):
  - With IE=1, a frame completes -> irq=1 one cycle after DONE. DATA read -> irq=0 next cycle.
  - With IE=0 -> irq stays 0.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// Parametrised SPI master on the CPU I/O bus: DATA/CTRL/DIV/STATUS registers, four SPI modes.
// Optional SPI_IRQ_EN adds a registered irq output (CTRL.IE & STATUS.DONE).
`ifndef LEN
`define LEN 32
`endif

module spi_master_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IONUM  = 1,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en_cs,
  input  logic              en_i,
  input  logic [`LEN-1:0]   addr_i,
  inout  logic [`LEN-1:0]   data,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCLK,
  output logic [IONUM-1:0]  CS
`ifdef SPI_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned     ECW       = $clog2(2 * DATA_W);
  localparam logic [ECW-1:0]  LAST_EDGE = ECW'(2 * DATA_W - 1);
  localparam logic [ECW-1:0]  EDGE_ONE  = ECW'(1);
  localparam logic [DIV_W:0]  CNT_ONE   = (DIV_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t             state_q, state_d;
  logic               cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, ie_q, ie_d;
  logic [2:0]         cs_sel_q, cs_sel_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DATA_W-1:0]  rx_q, rx_d, sh_q, sh_d, rxsh_q, rxsh_d;
  logic               busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  logic [DIV_W:0]     cnt_q, cnt_d;
  logic [ECW-1:0]     edge_q, edge_d;
  logic               sclk_q, sclk_d, mosi_q, mosi_d;
  logic [IONUM-1:0]   cs_q, cs_d, cs_mask;

  logic               bus_wr, bus_rd, tick, leading, do_sample;
  logic [DATA_W-1:0]  shifted;
  logic [`LEN-1:0]    rdata;
  logic               unused_ok;

  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  assign bus_wr    = en_cs & en_i;
  assign bus_rd    = en_cs & ~en_i;
  assign unused_ok = ^{addr_i, data};

  always_comb begin
    rdata = '0;
    case (addr_i[1:0])
      ADDR_DATA: rdata[DATA_W-1:0] = rx_q;
      ADDR_CTRL: rdata[6:0]        = {ie_q, cs_sel_q, lsb_q, cpha_q, cpol_q};
      ADDR_DIV:  rdata[DIV_W-1:0]  = div_q;
      default:   rdata[2:0]        = {ovr_q, done_q, busy_q};
    endcase
  end

  assign data = bus_rd ? rdata : 'z;

  always_comb begin
    cs_mask = '1;
    for (int unsigned i = 0; i < IONUM; i++) begin
      if (32'(cs_sel_q) == i) cs_mask[i] = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    lsb_d    = lsb_q;
    cs_sel_d = cs_sel_q;
    ie_d     = ie_q;
    div_d    = div_q;
    rx_d     = rx_q;
    busy_d   = busy_q;
    done_d   = done_q;
    ovr_d    = ovr_q;
    sh_d     = sh_q;
    rxsh_d   = rxsh_q;
    cnt_d    = cnt_q;
    edge_d   = edge_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_d     = cs_q;

    // >= rather than == so a DIV write mid-frame can never strand the counter
    tick      = (cnt_q >= {1'b0, div_q});
    leading   = ~edge_q[0];
    do_sample = (leading != cpha_q);
    shifted   = lsb_q ? (sh_q >> 1) : (sh_q << 1);

    if (bus_wr) begin
      case (addr_i[1:0])
        ADDR_DATA: if (busy_q) ovr_d = 1'b1;
        ADDR_CTRL: if (!busy_q) begin
          cpol_d   = data[0];
          cpha_d   = data[1];
          lsb_d    = data[2];
          cs_sel_d = data[5:3];
          ie_d     = data[6];
        end
        ADDR_DIV:  div_d = data[DIV_W-1:0];
        default: ;
      endcase
    end
    if (bus_rd && addr_i[1:0] == ADDR_DATA)   done_d = 1'b0;
    if (bus_rd && addr_i[1:0] == ADDR_STATUS) ovr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d = cpol_q;
        cs_d   = '1;
        if (bus_wr && addr_i[1:0] == ADDR_DATA && !busy_q) begin
          sh_d    = data[DATA_W-1:0];
          rxsh_d  = '0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          edge_d  = '0;
          cs_d    = cs_mask;
          state_d = SETUP;
          if (!cpha_q) mosi_d = first_bit(data[DATA_W-1:0], lsb_q);
        end
      end
      SETUP: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      SHIFT: begin
        if (tick) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_ONE;
          if (do_sample) begin
            rxsh_d = lsb_q ? {MISO, rxsh_q[DATA_W-1:1]} : {rxsh_q[DATA_W-2:0], MISO};
          end else if (cpha_q) begin
            mosi_d = first_bit(sh_q, lsb_q);
            sh_d   = shifted;
          end else begin
            sh_d   = shifted;
            mosi_d = first_bit(shifted, lsb_q);
          end
          if (edge_q == LAST_EDGE) begin
            edge_d  = '0;
            state_d = HOLD;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (tick) begin
          cnt_d   = '0;
          cs_d    = '1;
          rx_d    = rxsh_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      cs_sel_q <= '0;
      ie_q     <= 1'b0;
      div_q    <= '0;
      rx_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      sh_q     <= '0;
      rxsh_q   <= '0;
      cnt_q    <= '0;
      edge_q   <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_q     <= '1;
    end else begin
      state_q  <= state_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      lsb_q    <= lsb_d;
      cs_sel_q <= cs_sel_d;
      ie_q     <= ie_d;
      div_q    <= div_d;
      rx_q     <= rx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      sh_q     <= sh_d;
      rxsh_q   <= rxsh_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_q     <= cs_d;
    end
  end

  assign SCLK = sclk_q;
  assign MOSI = mosi_q;
  assign CS   = cs_q;

`ifdef SPI_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = ie_q & done_q;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) irq_q <= 1'b0;
    else      irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: MOSI bits and RX frames queued at stimulus, checked on output.
`ifndef LEN
`define LEN 32
`endif

module tb_spi_master_ctrl;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en_cs = 1'b0, en_i = 1'b0;
  logic [`LEN-1:0]   addr = '0, wdata = '0;
  wire  [`LEN-1:0]   data_w;
  logic              miso_lb = 1'b1, miso_val = 1'b0;
  wire               miso;
  logic              mosi, sclk;
  logic [0:0]        cs;
`ifdef SPI_IRQ_EN
  logic              irq;
`endif

  assign data_w = (en_cs && en_i) ? wdata : 'z;
  assign miso   = miso_lb ? mosi : miso_val;

  spi_master_ctrl #(.DATA_W(8), .IONUM(1), .DIV_W(8)) dut (
    .clk_in (clk),
    .rst    (rst_n),
    .en_cs  (en_cs),
    .en_i   (en_i),
    .addr_i (addr),
    .data   (data_w),
    .MISO   (miso),
    .MOSI   (mosi),
    .SCLK   (sclk),
    .CS     (cs)
`ifdef SPI_IRQ_EN
    ,
    .irq    (irq)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_pass = 0;
  logic        mosi_exp[$];
  logic [31:0] rx_exp[$];
  logic [31:0] last_rx = '0;
  logic        mon_en = 1'b0, mon_prev = 1'b0, cur_cpha = 1'b0;
  int unsigned mon_edges = 0, mon_cyc = 0, exp_T = 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    en_cs = 1'b1; en_i = 1'b1; addr = '0; addr[1:0] = a; wdata = v;
    @(posedge clk);
    #1 en_cs = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    @(negedge clk);
    en_cs = 1'b1; en_i = 1'b0; addr = '0; addr[1:0] = a;
    #1 v = data_w;
    @(posedge clk);
    #1 en_cs = 1'b0;
  endtask

  // Edge monitor: half-period spacing and MOSI value on every sampling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_cyc++;
      if (sclk !== mon_prev) begin
        if (mon_edges != 0) chk("half_period", mon_cyc, exp_T);
        if (((mon_edges % 2) == 0) == (cur_cpha == 1'b0) && mosi_exp.size() != 0)
          chk("mosi_bit", mosi, mosi_exp.pop_front());
        mon_edges++;
        mon_cyc = 0;
      end
      mon_prev = sclk;
    end
  end

  task automatic start_frame(input logic [7:0] ctrl, input logic [7:0] dv,
                             input logic [7:0] tx, input logic [7:0] exp_rx, input logic cs_on);
    logic [31:0] v;
    wr(2'd1, {24'd0, ctrl});
    wr(2'd2, {24'd0, dv});
    rd(2'd1, v); chk("ctrl_rd", v, {25'd0, ctrl[6:0]});
    rd(2'd2, v); chk("div_rd", v, {24'd0, dv});
    @(negedge clk);
    chk("sclk_idle", sclk, ctrl[0]);
    exp_T    = dv + 1;
    cur_cpha = ctrl[1];
    for (int i = 0; i < 8; i++) mosi_exp.push_back(ctrl[2] ? tx[i] : tx[7-i]);
    rx_exp.push_back({24'd0, exp_rx});
    mon_prev  = sclk;
    mon_cyc   = 0;
    mon_edges = 0;
    mon_en    = 1'b1;
    wr(2'd0, {24'd0, tx});
    @(negedge clk);
    chk("cs_active", cs, cs_on ? 32'd0 : 32'd1);
  endtask

  task automatic finish_frame();
    logic [31:0] st, v;
    st = '0;
    for (int i = 0; i < 1000 && st[1] !== 1'b1; i++) rd(2'd3, st);
    chk("done_set", st[1], 1);
    chk("busy_clr", st[0], 0);
    chk("edges", mon_edges, 16);
    mon_en = 1'b0;
    chk("cs_release", cs, 1);
    chk("mosi_left", mosi_exp.size(), 0);
    mosi_exp.delete();
    rd(2'd0, v);
    chk("rx", v, rx_exp.pop_front());
    last_rx = v;
    rd(2'd3, st);
    chk("done_clr", st[1], 0);
  endtask

`ifdef SPI_IRQ_EN
  task automatic irq_frame(input logic ie);
    logic [31:0] v;
    miso_lb = 1'b1;
    start_frame({1'b0, ie, 6'd0}, 8'd0, 8'h11, 8'h11, 1'b1);
    repeat (18) @(posedge clk);
    #1 chk("irq_at_done", irq, 0);
    rd(2'd3, v);
    chk("irq_status", v, 2);
    chk("irq_rise", irq, {31'd0, ie});
    rd(2'd0, v);
    chk("irq_rx", v, rx_exp.pop_front());
    chk("irq_hold", irq, {31'd0, ie});
    @(posedge clk);
    #1 chk("irq_fall", irq, 0);
    chk("irq_edges", mon_edges, 16);
    mon_en = 1'b0;
    chk("irq_mosi_left", mosi_exp.size(), 0);
    mosi_exp.delete();
    last_rx = 32'h11;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;

    // Reset
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_cs", cs, 1);
    chk("rst_mosi", mosi, 0);
    rd(2'd3, v); chk("rst_status", v, 0);
    rd(2'd1, v); chk("rst_ctrl", v, 0);
    rd(2'd0, v); chk("rst_rx", v, 0);

    // Mode 0, MSB first, loopback
    miso_lb = 1'b1;
    start_frame(8'h00, 8'd1, 8'hA5, 8'hA5, 1'b1);
    finish_frame();

    // Mode 3, LSB first, MISO tied high
    miso_lb = 1'b0; miso_val = 1'b1;
    start_frame(8'h07, 8'd0, 8'h3C, 8'hFF, 1'b1);
    finish_frame();
    @(negedge clk); chk("mode3_idle_high", sclk, 1);

    // Overrun and CTRL write while busy
    miso_lb = 1'b1;
    start_frame(8'h00, 8'd2, 8'hC3, 8'hC3, 1'b1);
    repeat (5) @(posedge clk);
    wr(2'd0, 32'h3C);
    wr(2'd1, 32'h01);
    rd(2'd3, v); chk("ovr_set", v, 5);
    rd(2'd3, v); chk("ovr_clr", v, 1);
    finish_frame();
    rd(2'd1, v); chk("ctrl_busy_ignored", v, 0);
    repeat (20) @(negedge clk);
    chk("ovr_no_second", sclk, 0);
    rd(2'd3, v); chk("ovr_idle_status", v, 0);

    // Out-of-range chip select
    start_frame(8'h28, 8'd0, 8'h69, 8'h69, 1'b0);
    finish_frame();

    // DATA write on completion cycle: ignored, OVR set
    start_frame(8'h00, 8'd0, 8'h5A, 8'h5A, 1'b1);
    repeat (17) @(posedge clk);
    wr(2'd0, 32'hFF);
    rd(2'd3, v); chk("end_write_status", v, 6);
    finish_frame();
    repeat (10) @(negedge clk);
    chk("end_write_no_frame", sclk, 0);

    // DATA read on completion cycle: old RX returned, DONE still set
    start_frame(8'h00, 8'd0, 8'h33, 8'h33, 1'b1);
    repeat (17) @(posedge clk);
    rd(2'd0, v); chk("end_read_old_rx", v, last_rx);
    finish_frame();

`ifdef SPI_IRQ_EN
    irq_frame(1'b1);
    irq_frame(1'b0);
`endif

    // Reset mid-frame
    start_frame(8'h00, 8'd3, 8'h96, 8'h96, 1'b1);
    for (int i = 0; i < 500 && mon_edges < 3; i++) @(negedge clk);
    chk("pre_reset_edges", mon_edges, 3);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sclk", sclk, 0);
    chk("midrst_cs", cs, 1);
    chk("midrst_mosi", mosi, 0);
    mosi_exp.delete();
    rx_exp.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rd(2'd0, v); chk("midrst_rx", v, 0);
    rd(2'd3, v); chk("midrst_status", v, 0);
    repeat (10) @(negedge clk);
    chk("midrst_idle_cs", cs, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
